fifo_mem_pipe: RTL and testbench
================================

Name: fifo_mem_pipe

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO storage array. Used by synchronous FIFOs and packet buffers.
- Adds per-lane byte-enable writes, an explicit read-enable with a valid flag, and a selectable 1- or 2-cycle read pipeline.
- Adds defined read-during-write collision behaviour.
- Storage only: no pointers and no full/empty tracking; those live in the FIFO controller.

Parameters:
- ADDR_WIDTH, 4, address bits; depth = 1<<ADDR_WIDTH entries.
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per byte-enable lane; LANES = DATA_WIDTH/LANE_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 only, anything else is an elaboration error.
- BYPASS, 1, same-address read-during-write policy: 1 = new data, 0 = old data.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous assert, active-low reset; release is synchronous to clk by the integrator.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  LANES  per-lane write enables; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- parity_err  out  1  present only with FIFO_MEM_PARITY_EN; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, parity_err=0.
  - Pipeline valid bits are cleared; in-flight reads are dropped with no rd_valid.
  - The array is NOT reset; unwritten entries read as X in simulation.
- Write:
  - On a clk edge with wr_en=1, lanes with wr_be[i]=1 update mem[wr_addr]; the other lanes keep their value.
  - wr_be=0 with wr_en=1 is a legal no-op.
- Read:
  - rd_en=1 sampled at edge N → rd_valid=1 and rd_data=result after edge N+RD_LATENCY-1, i.e. visible in cycle N+RD_LATENCY.
  - RD_LATENCY=1: array read is registered directly into rd_data.
  - RD_LATENCY=2: array read goes into an internal stage register, then into rd_data.
  - Back-to-back reads are fully pipelined: one result per cycle, no bubbles.
- rd_data hold: when rd_valid=0, rd_data holds its last value (no return to 0 except on reset); the stage register also holds.
- Collision (rd_en & wr_en, rd_addr==wr_addr, same edge):
  - BYPASS=1: per lane, enabled lanes return wr_data and disabled lanes return stored data.
  - BYPASS=0: all lanes return the pre-write contents.
  - A write at edge N+1 does not alter the read sampled at edge N, even when RD_LATENCY=2.
- Address wrap: addresses are natural modulo depth; there are no out-of-range cases.
- Different-address simultaneous read and write: independent, with no interaction.

Optional Feature:
- FIFO_MEM_PARITY_EN defined:
  - One even-parity bit is stored per lane, written with its lane.
  - Extra input inj_err (1 bit): when high with a write, inverts the stored parity of every enabled lane.
  - On read, any lane whose data XOR parity is 1 drives parity_err=1, aligned with rd_valid; parity_err is 0 whenever rd_valid=0.
  - Bypassed collision lanes use freshly computed parity, including inj_err.
- FIFO_MEM_PARITY_EN undefined: no parity storage, and neither inj_err nor parity_err exists; behaviour is otherwise identical.

Test Plan:
- Reset then basic access, RD_LATENCY=1: write 0xDEADBEEF @3, wr_be=4'hF; rd_en @3 at edge N → rd_valid=1, rd_data=0xDEADBEEF in cycle N+1; rd_valid=0 in cycle N+2 with rd_data held.
- Byte enables: write 0x11223344 @5 (be=F), then 0xAABBCCDD @5 with be=4'b0101; read @5 → 0x11BB33DD.
- Collision: mem[7]=0x00000000; same-edge write 0xFFFFFFFF be=4'b0011 and read @7. BYPASS=1 → 0x0000FFFF; BYPASS=0 → 0x00000000; a following read @7 → 0x0000FFFF in both.
- RD_LATENCY=2 streaming: fill 0..15 with data=addr*0x01010101; read addresses 0..15 on consecutive edges → rd_valid high 16 consecutive cycles starting 2 cycles after the first rd_en, with data in order.
- Reset mid-pipeline: RD_LATENCY=2, issue reads @1,@2, assert rst_n=0 one cycle later → rd_valid=0 and rd_data=0 immediately; no valid pulse after release; array contents survive (a read @1 afterwards returns the old data).
- Parity (macro on): write 0x12345678 @9 with inj_err=1, be=4'b0100; read @9 → rd_valid=1, parity_err=1; rewrite without injection; read → parity_err=0.

Source files
------------

// File: rtl/fifo_mem_pipe.sv
// fifo_mem_pipe: single-clock storage array for synchronous FIFOs and packet
// buffers. It provides byte-lane writes, a registered read path of 1 or 2
// cycles with a valid pulse, and a fixed same-address read-during-write policy
// (BYPASS=1 returns new data per enabled lane, BYPASS=0 returns old data).
// Optional build macro FIFO_MEM_PARITY_EN adds per-lane even parity storage,
// the inj_err input and the parity_err output.
module fifo_mem_pipe #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
`ifdef FIFO_MEM_PARITY_EN
  ,
  input  logic                             inj_err,
  output logic                             parity_err
`endif
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("fifo_mem_pipe: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
    $error("fifo_mem_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  // Replace the lanes selected by be with the new word, keep the rest.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < LANES; i++)
      if (be[i]) r[i*LANE_WIDTH +: LANE_WIDTH] = new_w[i*LANE_WIDTH +: LANE_WIDTH];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  coll_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;

  // Byte-lane write into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= merge_lanes(mem[wr_addr], wr_data, wr_be);
  end

  // Array read; a same-address write is merged in only when BYPASS selects new data.
  always_comb begin
    coll_p0    = wr_en && (wr_addr == rd_addr);
    rd_word_p0 = mem[rd_addr];
    if (BYPASS && coll_p0) rd_word_p0 = merge_lanes(mem[rd_addr], wr_data, wr_be);
  end

`ifdef FIFO_MEM_PARITY_EN
  // Even parity of every lane of a word.
  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^w[i*LANE_WIDTH +: LANE_WIDTH];
    return p;
  endfunction

  // Per-lane select between old and new parity bits.
  function automatic logic [LANES-1:0] merge_par(
    input logic [LANES-1:0] old_p,
    input logic [LANES-1:0] new_p,
    input logic [LANES-1:0] be
  );
    return (old_p & ~be) | (new_p & be);
  endfunction

  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_par_p0;
  logic             err_p0;

  assign wr_par = lane_parity(wr_data) ^ {LANES{inj_err}};

  // Parity bits are written together with their lanes.
  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= merge_par(par_mem[wr_addr], wr_par, wr_be);
  end

  // Parity check of the word being read, bypassed lanes use fresh parity.
  always_comb begin
    rd_par_p0 = par_mem[rd_addr];
    if (BYPASS && coll_p0) rd_par_p0 = merge_par(par_mem[rd_addr], wr_par, wr_be);
    err_p0 = |(lane_parity(rd_word_p0) ^ rd_par_p0);
  end
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
`ifdef FIFO_MEM_PARITY_EN
    logic                  err_p1;
`endif

    // ---- stage p0 -> p1: capture the array word; holds when no read issued.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        data_p1 <= rd_word_p0;
`ifdef FIFO_MEM_PARITY_EN
        err_p1  <= err_p0;
`endif
      end
    end

    // Stage valid; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= rd_en;
    end

    // ---- stage p1 -> output: present result with its valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data    <= '0;
        rd_valid   <= 1'b0;
`ifdef FIFO_MEM_PARITY_EN
        parity_err <= 1'b0;
`endif
      end else begin
        rd_valid   <= vld_p1;
        if (vld_p1) rd_data <= data_p1;
`ifdef FIFO_MEM_PARITY_EN
        parity_err <= vld_p1 & err_p1;
`endif
      end
    end
  end else begin : g_lat1
    // ---- stage p0 -> output: array word registered straight into rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data    <= '0;
        rd_valid   <= 1'b0;
`ifdef FIFO_MEM_PARITY_EN
        parity_err <= 1'b0;
`endif
      end else begin
        rd_valid   <= rd_en;
        if (rd_en) rd_data <= rd_word_p0;
`ifdef FIFO_MEM_PARITY_EN
        parity_err <= rd_en & err_p0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_mem_pipe.sv
// Testbench for fifo_mem_pipe: two instances share all inputs, one with
// RD_LATENCY=1/BYPASS=1 (dut_a) and one with RD_LATENCY=2/BYPASS=0 (dut_b).
// A word-level memory model records, per clock edge, what a read issued on
// that edge must return under each collision policy.
module tb_fifo_mem_pipe;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NL-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          inj_err = 1'b0;
  logic [DW-1:0] a_data, b_data;
  logic          a_vld, b_vld;
`ifdef FIFO_MEM_PARITY_EN
  logic          a_perr, b_perr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_mem_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW),
                  .RD_LATENCY(1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data),
    .rd_valid(a_vld)
`ifdef FIFO_MEM_PARITY_EN
    , .inj_err(inj_err), .parity_err(a_perr)
`endif
  );

  fifo_mem_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW),
                  .RD_LATENCY(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data),
    .rd_valid(b_vld)
`ifdef FIFO_MEM_PARITY_EN
    , .inj_err(inj_err), .parity_err(b_perr)
`endif
  );

  // Reference model
  typedef struct {
    logic          vld;
    logic [DW-1:0] dnew;
    logic [DW-1:0] dold;
    logic          enew;
    logic          eold;
  } rd_rec_t;

  logic [DW-1:0] m_mem [DEPTH];
  logic [NL-1:0] m_par [DEPTH];
  rd_rec_t       hist[$];
  logic [DW-1:0] hold_a = '0, hold_b = '0;
  logic          ea_vld = 1'b0, eb_vld = 1'b0, ea_perr = 1'b0, eb_perr = 1'b0;
  logic [DW-1:0] ea_data = '0, eb_data = '0;

  task automatic clear_model_outputs();
    hist.delete();
    hold_a = '0; hold_b = '0;
    ea_vld = 1'b0; eb_vld = 1'b0; ea_perr = 1'b0; eb_perr = 1'b0;
    ea_data = '0; eb_data = '0;
  endtask

  // Evaluate the current inputs against the model, advance one clock edge and
  // derive what each instance must show just after that edge.
  task automatic cycle();
    rd_rec_t       r, ra, rb;
    logic [DW-1:0] old_w, new_w;
    logic [NL-1:0] old_p, new_p, fresh_p;
    old_w = m_mem[rd_addr];
    old_p = m_par[rd_addr];
    new_w = old_w;
    new_p = old_p;
    for (int i = 0; i < NL; i++) fresh_p[i] = (^wr_data[i*LW +: LW]) ^ inj_err;
    if (wr_en && wr_addr == rd_addr)
      for (int i = 0; i < NL; i++)
        if (wr_be[i]) begin
          new_w[i*LW +: LW] = wr_data[i*LW +: LW];
          new_p[i] = fresh_p[i];
        end
    r.vld  = rd_en && rst_n;
    r.dold = old_w;
    r.dnew = new_w;
    r.eold = 1'b0;
    r.enew = 1'b0;
    for (int i = 0; i < NL; i++) begin
      r.eold = r.eold | ((^old_w[i*LW +: LW]) ^ old_p[i]);
      r.enew = r.enew | ((^new_w[i*LW +: LW]) ^ new_p[i]);
    end
    if (wr_en)
      for (int i = 0; i < NL; i++)
        if (wr_be[i]) begin
          m_mem[wr_addr][i*LW +: LW] = wr_data[i*LW +: LW];
          m_par[wr_addr][i] = fresh_p[i];
        end
    hist.push_back(r);
    if (hist.size() > 2) void'(hist.pop_front());
    @(posedge clk);
    #1;
    if (!rst_n) begin
      clear_model_outputs();
    end else begin
      ra = hist[hist.size()-1];
      if (ra.vld) hold_a = ra.dnew;
      ea_vld  = ra.vld;
      ea_data = hold_a;
      ea_perr = ra.vld & ra.enew;
      eb_vld  = 1'b0;
      eb_perr = 1'b0;
      if (hist.size() == 2) begin
        rb = hist[0];
        if (rb.vld) hold_b = rb.dold;
        eb_vld  = rb.vld;
        eb_perr = rb.vld & rb.eold;
      end
      eb_data = hold_b;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; inj_err = 1'b0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) cycle();
    checks++;
    if (a_vld !== 1'b0 || a_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_a: vld=%b data=%h expected vld=0 data=00000000", a_vld, a_data);
    end
    checks++;
    if (b_vld !== 1'b0 || b_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_b: vld=%b data=%h expected vld=0 data=00000000", b_vld, b_data);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: a_vld=%b b_vld=%b expected 0 0", a_vld, b_vld);
    end
  endtask

  task automatic test_basic();
    idle(); set_wr(3, 32'hDEADBEEF, 4'hF); cycle();
    idle(); set_rd(3); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_a_read: vld=%b data=%h expected vld=1 data=deadbeef", a_vld, a_data);
    end
    idle(); cycle();
    checks++;
    if (a_vld !== 1'b0 || a_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_a_hold: vld=%b data=%h expected vld=0 data=deadbeef", a_vld, a_data);
    end
    checks++;
    if (b_vld !== 1'b1 || b_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_b_read: vld=%b data=%h expected vld=1 data=deadbeef", b_vld, b_data);
    end
    cycle();
    checks++;
    if (b_vld !== 1'b0 || b_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_b_hold: vld=%b data=%h expected vld=0 data=deadbeef", b_vld, b_data);
    end
  endtask

  task automatic test_byte_en();
    idle(); set_wr(5, 32'h11223344, 4'hF); cycle();
    idle(); set_wr(5, 32'hAABBCCDD, 4'b0101); cycle();
    idle(); set_rd(5); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_en_a: vld=%b data=%h expected vld=1 data=11bb33dd", a_vld, a_data);
    end
    idle(); cycle();
    checks++;
    if (b_vld !== 1'b1 || b_data !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_en_b: vld=%b data=%h expected vld=1 data=11bb33dd", b_vld, b_data);
    end
  endtask

  task automatic test_collision();
    idle(); set_wr(7, 32'h0, 4'hF); cycle();
    idle(); set_wr(7, 32'hFFFFFFFF, 4'b0011); set_rd(7); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL collision_new: data=%h expected 0000ffff", a_data);
    end
    idle(); set_rd(7); cycle();
    checks++;
    if (b_vld !== 1'b1 || b_data !== 32'h00000000) begin
      failures++;
      $display("FAIL collision_old: data=%h expected 00000000", b_data);
    end
    checks++;
    if (a_data !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL collision_after_a: data=%h expected 0000ffff", a_data);
    end
    idle(); cycle();
    checks++;
    if (b_vld !== 1'b1 || b_data !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL collision_after_b: data=%h expected 0000ffff", b_data);
    end
  endtask

  // Fill with addr*0x01010101, then stream 16 reads; each read address is
  // overwritten on the following edge, which must not disturb the read.
  task automatic test_stream();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    for (int a = 0; a < DEPTH; a++) begin
      idle(); set_wr(a[AW-1:0], a * 32'h01010101, 4'hF); cycle();
    end
    for (int j = 0; j < DEPTH + 3; j++) begin
      idle();
      if (j < DEPTH) set_rd(j[AW-1:0]);
      if (j >= 1 && j <= DEPTH) set_wr(AW'(j - 1), ~((j - 1) * 32'h01010101), 4'hF);
      cycle();
      exp_v = (j >= 1 && j <= DEPTH);
      exp_d = (j - 1) * 32'h01010101;
      checks++;
      if (b_vld !== exp_v || (exp_v && b_data !== exp_d)) begin
        failures++;
        $display("FAIL stream_b[%0d]: vld=%b data=%h expected vld=%b data=%h", j, b_vld, b_data, exp_v, exp_d);
      end
      checks++;
      if (a_vld !== ea_vld || a_data !== ea_data) begin
        failures++;
        $display("FAIL stream_a[%0d]: vld=%b data=%h expected vld=%b data=%h", j, a_vld, a_data, ea_vld, ea_data);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      idle();
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_be   = NL'($urandom);
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
`ifdef FIFO_MEM_PARITY_EN
      inj_err = ($urandom_range(0, 7) == 0);
`endif
      cycle();
      checks++;
      if (a_vld !== ea_vld || a_data !== ea_data) begin
        failures++;
        $display("FAIL random_a[%0d]: vld=%b data=%h expected vld=%b data=%h", n, a_vld, a_data, ea_vld, ea_data);
      end
      checks++;
      if (b_vld !== eb_vld || b_data !== eb_data) begin
        failures++;
        $display("FAIL random_b[%0d]: vld=%b data=%h expected vld=%b data=%h", n, b_vld, b_data, eb_vld, eb_data);
      end
`ifdef FIFO_MEM_PARITY_EN
      checks++;
      if (a_perr !== ea_perr || b_perr !== eb_perr) begin
        failures++;
        $display("FAIL random_perr[%0d]: a=%b b=%b expected a=%b b=%b", n, a_perr, b_perr, ea_perr, eb_perr);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    idle(); set_wr(1, 32'hCAFEF00D, 4'hF); cycle();
    idle(); set_wr(2, 32'h0BADC0DE, 4'hF); cycle();
    idle(); set_rd(1); cycle();
    idle(); set_rd(2); cycle();
    idle();
    rst_n = 1'b0;
    #1;
    clear_model_outputs();
    checks++;
    if (a_vld !== 1'b0 || a_data !== 32'h0 || b_vld !== 1'b0 || b_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_async: a=%b/%h b=%b/%h expected 0/00000000", a_vld, a_data, b_vld, b_data);
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (a_vld !== 1'b0 || b_vld !== 1'b0 || b_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid_drop[%0d]: a_vld=%b b_vld=%b b_data=%h expected 0 0 00000000", k, a_vld, b_vld, b_data);
      end
    end
    set_rd(1); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL reset_mid_keep_a: vld=%b data=%h expected vld=1 data=cafef00d", a_vld, a_data);
    end
    idle(); cycle();
    checks++;
    if (b_vld !== 1'b1 || b_data !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL reset_mid_keep_b: vld=%b data=%h expected vld=1 data=cafef00d", b_vld, b_data);
    end
  endtask

`ifdef FIFO_MEM_PARITY_EN
  task automatic test_parity();
    idle(); set_wr(9, 32'h12345678, 4'b0100); inj_err = 1'b1; cycle();
    idle(); set_rd(9); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_perr !== 1'b1) begin
      failures++;
      $display("FAIL parity_inj_a: vld=%b perr=%b expected 1 1", a_vld, a_perr);
    end
    idle(); cycle();
    checks++;
    if (b_perr !== 1'b1 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL parity_inj_b: b_perr=%b a_perr=%b expected 1 0", b_perr, a_perr);
    end
    set_wr(9, 32'h12345678, 4'b0100); cycle();
    idle(); set_rd(9); cycle();
    checks++;
    if (a_vld !== 1'b1 || a_perr !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean_a: vld=%b perr=%b expected 1 0", a_vld, a_perr);
    end
    idle(); cycle();
    checks++;
    if (b_vld !== 1'b1 || b_perr !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean_b: vld=%b perr=%b expected 1 0", b_vld, b_perr);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_en();
    test_collision();
    test_stream();
    test_random();
    test_reset_mid();
`ifdef FIFO_MEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
